// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, instruction classes,
// opcode/funct values and the ALU/mux select codes also used by the datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_ALU_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_JR, C_BEQ, C_BNE, C_IMM, C_LW, C_SW, C_J, C_JAL, C_BAD
  } cls_e;

  localparam int OP_RTYPE = 0;
  localparam int OP_J     = 2;
  localparam int OP_JAL   = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_ADDI  = 8;
  localparam int OP_SLTI  = 10;
  localparam int OP_SLTIU = 11;
  localparam int OP_ANDI  = 12;
  localparam int OP_ORI   = 13;
  localparam int OP_XORI  = 14;
  localparam int OP_LUI   = 15;
  localparam int OP_LW    = 35;
  localparam int OP_SW    = 43;
  localparam int FN_JR    = 8;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_FUNCT = 3'b110;

  localparam logic [2:0] SRCB_REGB = 3'b000;
  localparam logic [2:0] SRCB_SEXT = 3'b001;
  localparam logic [2:0] SRCB_ZEXT = 3'b010;
  localparam logic [2:0] SRCB_LUI  = 3'b011;
  localparam logic [2:0] SRCB_FOUR = 3'b100;
  localparam logic [2:0] SRCB_BR   = 3'b101;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_opdec.sv
// Opcode/funct classifier: instruction class plus the immediate-form ALU
// source and operation used in EXEC_I.
module ctrl_opdec
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  output cls_e           cls,
  output logic [2:0]     srcb,
  output logic [2:0]     aluop
);

  always_comb begin
    cls   = C_BAD;
    srcb  = SRCB_SEXT;
    aluop = ALU_ADD;
    case (int'(opcode))
      OP_RTYPE: cls = (int'(funct) == FN_JR) ? C_JR : C_R;
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      OP_BEQ:   cls = C_BEQ;
      OP_BNE:   cls = C_BNE;
      OP_LW:    cls = C_LW;
      OP_SW:    cls = C_SW;
      OP_ADDI:  cls = C_IMM;
      OP_SLTI, OP_SLTIU: begin
        cls   = C_IMM;
        aluop = ALU_SLT;
      end
      OP_ANDI: begin
        cls   = C_IMM;
        srcb  = SRCB_ZEXT;
        aluop = ALU_AND;
      end
      OP_ORI: begin
        cls   = C_IMM;
        srcb  = SRCB_ZEXT;
        aluop = ALU_OR;
      end
      OP_XORI: begin
        cls   = C_IMM;
        srcb  = SRCB_ZEXT;
        aluop = ALU_XOR;
      end
      OP_LUI: begin
        cls   = C_IMM;
        srcb  = SRCB_LUI;
      end
      default: cls = C_BAD;
    endcase
  end

endmodule

// File: rtl/ctrl_multicycle.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with a bounded memory-ready wait and a sticky trap for bad opcodes or timeouts.
module ctrl_multicycle
  import ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int ALUOPW      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPW-1:0]    opcode,
  input  logic [OPW-1:0]    funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_eq,
  output logic              pc_write_ne,
  output logic [1:0]        pc_source,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic [1:0]        reg_dst,
  output logic              mem_to_reg,
  output logic              jal,
  output logic              alu_src_a,
  output logic [2:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              illegal,
  output logic [3:0]        state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 4;

  state_e      st, st_nxt;
  cls_e        cls;
  logic [2:0]  dec_srcb, dec_aluop, aluop3;
  logic [CW-1:0] wait_cnt;
  logic        illegal_q, tmo, mem_st;

  // Branch outcome is resolved in the datapath through pc_write_eq/ne.
  logic unused_zero;
  assign unused_zero = zero;

  ctrl_opdec #(.OPW(OPW)) u_opdec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls),
    .srcb   (dec_srcb),
    .aluop  (dec_aluop)
  );

  assign mem_st = is_mem_state(st);
  // Fires on the last allowed waiting cycle; a ready in that same cycle still wins.
  assign tmo = (MEM_TIMEOUT > 0) && (int'(wait_cnt) >= MEM_TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
    end else begin
      st        <= st_nxt;
      illegal_q <= illegal_q | (st_nxt == S_TRAP);
      if (st_nxt != st)
        wait_cnt <= '0;
      else if (mem_st && !mem_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:     st_nxt = S_FETCH;
      S_FETCH:    st_nxt = mem_ready ? S_DECODE : (tmo ? S_TRAP : S_FETCH);
      S_DECODE: begin
        case (cls)
          C_R:          st_nxt = S_EXEC_R;
          C_IMM:        st_nxt = S_EXEC_I;
          C_BEQ, C_BNE: st_nxt = S_BRANCH;
          C_LW, C_SW:   st_nxt = S_MEM_ADDR;
          C_J, C_JAL, C_JR: st_nxt = S_JUMP;
          default:      st_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: st_nxt = S_ALU_WB;
      S_MEM_ADDR: st_nxt = (cls == C_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   st_nxt = mem_ready ? S_MEM_WB : (tmo ? S_TRAP : S_MEM_RD);
      S_MEM_WR:   st_nxt = mem_ready ? S_FETCH : (tmo ? S_TRAP : S_MEM_WR);
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: st_nxt = S_FETCH;
      S_TRAP:     st_nxt = S_TRAP;
      default:    st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_source   = PCS_ALU;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = RD_RT;
    mem_to_reg  = 1'b0;
    jal         = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    aluop3      = ALU_ADD;
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_BR;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aluop3    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = dec_srcb;
        aluop3    = dec_aluop;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (cls == C_R) ? RD_RD : RD_RT;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        aluop3      = ALU_SUB;
        pc_source   = PCS_ALUOUT;
        pc_write_eq = (cls == C_BEQ);
        pc_write_ne = (cls == C_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = (cls == C_JR) ? PCS_REGA : PCS_JUMP;
        if (cls == C_JAL) begin
          reg_write = 1'b1;
          reg_dst   = RD_RA;
          jal       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign alu_op  = ALUOPW'(aluop3);
  assign illegal = illegal_q;
  assign state   = st;

endmodule

// File: tb/tb_ctrl_multicycle.sv
// Directed bench for ctrl_multicycle: per-instruction vector table plus
// hand sequences for memory stalls, timeout, trap and mid-instruction reset.
module tb_ctrl_multicycle;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
    EXEC_I = 4'd4, MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB = 4'd7, MEM_WR = 4'd8,
    ALU_WB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11, TRAP = 4'd12;

  logic clk = 1'b0, rst_n;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write;
  logic reg_write, mem_to_reg, jal, alu_src_a, illegal;
  logic [1:0] pc_source, reg_dst;
  logic [2:0] alu_src_b, alu_op;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  ctrl_multicycle dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_eq(pc_write_eq),
    .pc_write_ne(pc_write_ne), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [20:0] obus;
  assign obus = {pc_write, pc_write_eq, pc_write_ne, pc_source, i_or_d, mem_read,
                 mem_write, ir_write, reg_write, reg_dst, mem_to_reg, jal,
                 alu_src_a, alu_src_b, alu_op};

  function automatic logic [20:0] eo(input logic pcw, eq, ne, input logic [1:0] pcs,
                                     input logic iord, mr, mw, irw, rw,
                                     input logic [1:0] rd, input logic m2r, jl, a,
                                     input logic [2:0] b, op);
    return {pcw, eq, ne, pcs, iord, mr, mw, irw, rw, rd, m2r, jl, a, b, op};
  endfunction

  typedef struct {
    string            nm;
    logic [5:0]       op;
    logic [5:0]       fn;
    int               n;
    logic [2:0][3:0]  st;
    logic [2:0][20:0] o;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input string nm, input logic [5:0] op, fn,
                         input int n, input logic [3:0] s0, input logic [20:0] o0,
                         input logic [3:0] s1, input logic [20:0] o1,
                         input logic [3:0] s2, input logic [20:0] o2);
    tv[i].nm = nm; tv[i].op = op; tv[i].fn = fn; tv[i].n = n;
    tv[i].st[0] = s0; tv[i].st[1] = s1; tv[i].st[2] = s2;
    tv[i].o[0] = o0; tv[i].o[1] = o1; tv[i].o[2] = o2;
  endtask

  // Entered with the FSM in FETCH, just after a clock edge.
  task automatic run_vec(input int i, input logic [20:0] f_rdy, input logic [20:0] dec);
    opcode = tv[i].op; funct = tv[i].fn; mem_ready = 1'b1;
    #1;
    chk({tv[i].nm, " fetch state"}, 32'(state), 32'(FETCH));
    chk({tv[i].nm, " fetch outs"}, 32'(obus), 32'(f_rdy));
    tick();
    chk({tv[i].nm, " decode state"}, 32'(state), 32'(DECODE));
    chk({tv[i].nm, " decode outs"}, 32'(obus), 32'(dec));
    for (int k = 0; k < tv[i].n; k++) begin
      tick();
      chk($sformatf("%s state%0d", tv[i].nm, k), 32'(state), 32'(tv[i].st[k]));
      chk($sformatf("%s outs%0d", tv[i].nm, k), 32'(obus), 32'(tv[i].o[k]));
    end
    tick();
    chk({tv[i].nm, " back to fetch"}, 32'(state), 32'(FETCH));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset state", 32'(state), 32'(IDLE));
    chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset outs", 32'(obus), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle->fetch", 32'(state), 32'(FETCH));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [20:0] f_rdy, f_wait, dec, exr, wb_rt, wb_rd, maddr, mrd, mwb, mwr, z;
    f_rdy  = eo(1,0,0,2'b00,0,1,0,1,0,2'b00,0,0,0,3'b100,3'b000);
    f_wait = eo(0,0,0,2'b00,0,1,0,0,0,2'b00,0,0,0,3'b100,3'b000);
    dec    = eo(0,0,0,2'b00,0,0,0,0,0,2'b00,0,0,0,3'b101,3'b000);
    exr    = eo(0,0,0,2'b00,0,0,0,0,0,2'b00,0,0,1,3'b000,3'b110);
    wb_rt  = eo(0,0,0,2'b00,0,0,0,0,1,2'b00,0,0,0,3'b000,3'b000);
    wb_rd  = eo(0,0,0,2'b00,0,0,0,0,1,2'b01,0,0,0,3'b000,3'b000);
    maddr  = eo(0,0,0,2'b00,0,0,0,0,0,2'b00,0,0,1,3'b001,3'b000);
    mrd    = eo(0,0,0,2'b00,1,1,0,0,0,2'b00,0,0,0,3'b000,3'b000);
    mwb    = eo(0,0,0,2'b00,0,0,0,0,1,2'b00,1,0,0,3'b000,3'b000);
    mwr    = eo(0,0,0,2'b00,1,0,1,0,0,2'b00,0,0,0,3'b000,3'b000);
    z      = '0;

    set_vec(0,  "add",   6'd0,  6'd32, 2, EXEC_R, exr, ALU_WB, wb_rd, IDLE, z);
    set_vec(1,  "addi",  6'd8,  6'd0,  2, EXEC_I, eo(0,0,0,0,0,0,0,0,0,0,0,0,1,3'b001,3'b000), ALU_WB, wb_rt, IDLE, z);
    set_vec(2,  "slti",  6'd10, 6'd0,  2, EXEC_I, eo(0,0,0,0,0,0,0,0,0,0,0,0,1,3'b001,3'b101), ALU_WB, wb_rt, IDLE, z);
    set_vec(3,  "sltiu", 6'd11, 6'd0,  2, EXEC_I, eo(0,0,0,0,0,0,0,0,0,0,0,0,1,3'b001,3'b101), ALU_WB, wb_rt, IDLE, z);
    set_vec(4,  "andi",  6'd12, 6'd0,  2, EXEC_I, eo(0,0,0,0,0,0,0,0,0,0,0,0,1,3'b010,3'b010), ALU_WB, wb_rt, IDLE, z);
    set_vec(5,  "ori",   6'd13, 6'd0,  2, EXEC_I, eo(0,0,0,0,0,0,0,0,0,0,0,0,1,3'b010,3'b011), ALU_WB, wb_rt, IDLE, z);
    set_vec(6,  "xori",  6'd14, 6'd0,  2, EXEC_I, eo(0,0,0,0,0,0,0,0,0,0,0,0,1,3'b010,3'b100), ALU_WB, wb_rt, IDLE, z);
    set_vec(7,  "lui",   6'd15, 6'd0,  2, EXEC_I, eo(0,0,0,0,0,0,0,0,0,0,0,0,1,3'b011,3'b000), ALU_WB, wb_rt, IDLE, z);
    set_vec(8,  "beq",   6'd4,  6'd0,  1, BRANCH, eo(0,1,0,2'b01,0,0,0,0,0,0,0,0,1,3'b000,3'b001), IDLE, z, IDLE, z);
    set_vec(9,  "bne",   6'd5,  6'd0,  1, BRANCH, eo(0,0,1,2'b01,0,0,0,0,0,0,0,0,1,3'b000,3'b001), IDLE, z, IDLE, z);
    set_vec(10, "j",     6'd2,  6'd0,  1, JUMP, eo(1,0,0,2'b10,0,0,0,0,0,0,0,0,0,3'b000,3'b000), IDLE, z, IDLE, z);
    set_vec(11, "jal",   6'd3,  6'd0,  1, JUMP, eo(1,0,0,2'b10,0,0,0,0,1,2'b10,0,1,0,3'b000,3'b000), IDLE, z, IDLE, z);
    set_vec(12, "jr",    6'd0,  6'd8,  1, JUMP, eo(1,0,0,2'b11,0,0,0,0,0,0,0,0,0,3'b000,3'b000), IDLE, z, IDLE, z);
    set_vec(13, "lw",    6'd35, 6'd0,  3, MEM_ADDR, maddr, MEM_RD, mrd, MEM_WB, mwb);
    set_vec(14, "sw",    6'd43, 6'd0,  2, MEM_ADDR, maddr, MEM_WR, mwr, IDLE, z);

    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("por state", 32'(state), 32'(IDLE));
    chk("por outs", 32'(obus), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("por idle->fetch", 32'(state), 32'(FETCH));
    chk("fetch stall outs", 32'(obus), 32'(f_wait));
    zero = 1'b1;  // branch outputs must not follow zero
    for (int i = 0; i < 15; i++) run_vec(i, f_rdy, dec);
    zero = 1'b0;

    // lw with three not-ready cycles in MEM_RD
    opcode = 6'd35; mem_ready = 1'b1;
    tick(); tick();
    chk("lw stall maddr", 32'(state), 32'(MEM_ADDR));
    mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lw stall rd%0d", k), 32'(state), 32'(MEM_RD));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw stall rd4", 32'(state), 32'(MEM_RD));
    chk("lw stall rd4 outs", 32'(obus), 32'(mrd));
    tick();
    chk("lw stall wb", 32'(state), 32'(MEM_WB));
    chk("lw stall m2r", 32'(mem_to_reg), 32'd1);
    tick();
    chk("lw stall fetch", 32'(state), 32'(FETCH));

    // ready on the 15th waiting cycle still completes the fetch
    mem_ready = 1'b0; opcode = 6'd2;
    repeat (14) tick();
    chk("fetch 14 waits", 32'(state), 32'(FETCH));
    mem_ready = 1'b1;
    #1;
    chk("fetch late ir_write", 32'(ir_write), 32'd1);
    tick();
    chk("fetch late decode", 32'(state), 32'(DECODE));
    chk("fetch late no trap", 32'(illegal), 32'd0);
    tick(); tick();
    chk("j after late fetch", 32'(state), 32'(FETCH));

    // fetch timeout
    mem_ready = 1'b0;
    repeat (14) tick();
    chk("tmo still fetch", 32'(state), 32'(FETCH));
    tick();
    chk("tmo trap", 32'(state), 32'(TRAP));
    chk("tmo illegal", 32'(illegal), 32'd1);
    chk("tmo outs", 32'(obus), 32'd0);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("trap absorbing", 32'(state), 32'(TRAP));
    chk("trap sticky", 32'(illegal), 32'd1);
    do_reset();

    // undefined opcode
    opcode = 6'd63; mem_ready = 1'b1;
    tick(); tick();
    chk("op63 trap", 32'(state), 32'(TRAP));
    chk("op63 illegal", 32'(illegal), 32'd1);
    tick();
    chk("op63 sticky", 32'(illegal), 32'd1);
    do_reset();

    // reset in the middle of a stalled store
    opcode = 6'd43; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("sw wr state", 32'(state), 32'(MEM_WR));
    chk("sw mem_write", 32'(mem_write), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst state", 32'(state), 32'(IDLE));
    chk("midrst mem_write", 32'(mem_write), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst fetch", 32'(state), 32'(FETCH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
